// File: rtl/seq_divider.sv
// Sequential 8-bit restoring divider: one quotient bit per cycle, IDLE/RUN/DONE control.
// Define DIV_SIGNED_EN to add the sgn port and two's-complement operation.
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
`ifdef DIV_SIGNED_EN
    input  logic       sgn,
`endif
    output logic [7:0] quot,
    output logic [7:0] rem,
    output logic       busy,
    output logic       done,
    output logic       DZ,
    output logic       V
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic [2:0] cnt;
    logic       load;
    logic [7:0] a_l, b_l;
    logic       sgn_l;
    logic [7:0] dvd, r, dvs;
    logic       neg_q, neg_r;
    logic       v_r;

    logic       sgn_in;
    logic       ovf;
    logic [8:0] trial;
    logic       fits;
    logic [7:0] r_nxt, q_nxt, q_fix, r_fix, a_mag, b_mag;

`ifdef DIV_SIGNED_EN
    assign sgn_in = sgn;
    assign ovf    = sgn_l && (a_l == 8'h80) && (b_l == 8'hFF);
`else
    assign sgn_in = 1'b0;
    assign ovf    = 1'b0;
`endif

    assign V = v_r;

    // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
    always_comb begin
        trial = {r, dvd[7]};
        fits  = (trial >= {1'b0, dvs});
        r_nxt = fits ? (trial[7:0] - dvs) : trial[7:0];
        q_nxt = {dvd[6:0], fits};
        q_fix = neg_q ? (~q_nxt + 8'd1) : q_nxt;
        r_fix = neg_r ? (~r_nxt + 8'd1) : r_nxt;
        a_mag = (sgn_l && a_l[7]) ? (~a_l + 8'd1) : a_l;
        b_mag = (sgn_l && b_l[7]) ? (~b_l + 8'd1) : b_l;
    end

    // The first RUN cycle (load=1) checks the latched divisor and sets up magnitudes;
    // the next eight cycles each retire one quotient bit, MSB first.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            load  <= 1'b0;
            quot  <= 8'd0;
            rem   <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            DZ    <= 1'b0;
            v_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        a_l   <= A;
                        b_l   <= B;
                        sgn_l <= sgn_in;
                        DZ    <= 1'b0;
                        v_r   <= 1'b0;
                        cnt   <= 3'd0;
                        load  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        load <= 1'b0;
                        if (b_l == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            DZ    <= 1'b1;
                            quot  <= 8'hFF;
                            rem   <= a_l;
                        end else begin
                            busy  <= 1'b1;
                            dvd   <= a_mag;
                            dvs   <= b_mag;
                            r     <= 8'd0;
                            neg_q <= sgn_l && (a_l[7] ^ b_l[7]);
                            neg_r <= sgn_l && a_l[7];
                            cnt   <= 3'd0;
                        end
                    end else begin
                        dvd <= q_nxt;
                        r   <= r_nxt;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            quot  <= q_fix;
                            rem   <= r_fix;
                            v_r   <= ovf;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    load  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE or DONE.
REQ-004 The block SHALL have port A, input, 8 bits: dividend; captured on the accepting edge.
REQ-005 The block SHALL have port B, input, 8 bits: divisor; captured on the accepting edge.
REQ-006 The block SHALL have port quot, output, 8 bits: quotient, registered.
REQ-007 The block SHALL have port rem, output, 8 bits: remainder, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while iterating.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when quot, rem, DZ and V are valid.
REQ-010 The block SHALL have port DZ, output, 1 bit: divide-by-zero flag, registered.
REQ-011 The block SHALL have port V, output, 1 bit: overflow flag, registered.

Function
REQ-012 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 on edge N SHALL latch A and B and clear done, DZ and V.
REQ-014 If the latched divisor is nonzero, the machine SHALL go to RUN with the iteration counter set to 0.
REQ-015 In RUN, the block SHALL perform one restoring step per cycle, MSB first, with a 9-bit partial-remainder compare.
REQ-016 Normal latency SHALL be as follows: busy=1 after edges N+1..N+8, done=1 and outputs valid after edge N+9, done=0 after edge N+10.
REQ-017 If the divisor is zero, the block SHALL return quot=8'hFF, rem=A, DZ=1, done=1 after edge N+1, with busy never asserted.
REQ-018 The transition from RUN to DONE SHALL happen when the counter reaches 7 (8 steps).
REQ-019 DONE SHALL last one cycle and then return to IDLE, unless start=1, which re-accepts directly.
REQ-020 start while in RUN SHALL be ignored; A and B changes during RUN SHALL have no effect.
REQ-021 quot, rem, DZ and V SHALL hold their last result until the next accepted start, which clears them; quot and rem are overwritten only at completion.
REQ-022 V SHALL be 0 in unsigned operation.

Reset
REQ-023 rst=1 SHALL, on the next edge, force state IDLE and quot=0, rem=0, busy=0, done=0, DZ=0, V=0, counter=0.
REQ-024 rst SHALL take priority over start and abort any division in progress, with no done pulse for the aborted operation.
REQ-025 After rst deasserts, the first start SHALL be accepted on that same edge if start=1.

Configuration
REQ-026 The macro DIV_SIGNED_EN SHALL control signed operation.
REQ-027 When DIV_SIGNED_EN is defined, the block SHALL add input port sgn, 1 bit, latched with A and B.
REQ-028 With sgn=1, operands SHALL be two's complement, the quotient SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-029 Signed operation SHALL implement magnitude division plus sign fix-up within the same 8 RUN cycles, so latency is unchanged.
REQ-030 For signed -128/-1, the block SHALL return quot=8'h80, rem=0, V=1.
REQ-031 For signed divide-by-zero, the block SHALL follow the REQ-017 result with quot=8'hFF.
REQ-032 When DIV_SIGNED_EN is undefined, the sgn port SHALL be absent, all division SHALL be unsigned, and V SHALL be tied 0.

Verification
REQ-033 The bench SHALL check: A=200, B=7, start on edge N -> busy edges N+1..N+8; done after N+9 with quot=28, rem=4, DZ=0, V=0.
REQ-034 The bench SHALL check: A=5, B=0 -> after N+1: done=1, quot=8'hFF, rem=8'h05, DZ=1; busy stays 0.
REQ-035 The bench SHALL check: A=255, B=1, then start=1 again in the DONE cycle with A=9, B=3 -> first done gives quot=255, rem=0; second result quot=3, rem=0 with no IDLE gap.
REQ-036 The bench SHALL check: A=100, B=10 accepted, then start=1 with A=1, B=1 at N+3 -> ignored; done after N+9 with quot=10, rem=0.
REQ-037 The bench SHALL check: rst=1 at N+4 mid-RUN -> all outputs 0 next edge; no done pulse; a following start of 50/5 gives quot=10, rem=0.
REQ-038 The bench SHALL check, with DIV_SIGNED_EN and sgn=1: A=8'h9C (-100), B=7 -> quot=8'hF2 (-14), rem=8'hFE (-2); A=8'h80, B=8'hFF -> quot=8'h80, rem=0, V=1.
